// File: rtl/fxp_calc_pkg.sv
// Shared Q9.6 calculator definitions: op encodings, ALU states, format limits and
// iteration counts. Also imported by the downstream 7-segment decoder.
package fxp_calc_pkg;

    localparam int unsigned FXP_WIDTH     = 16;
    localparam int unsigned FXP_FRAC_BITS = 6;

    localparam logic [FXP_WIDTH-1:0] FXP_MAX = 16'h7FFF;
    localparam logic [FXP_WIDTH-1:0] FXP_MIN = 16'h8000;

    localparam int unsigned MUL_ITERS = 16;
    localparam int unsigned DIV_ITERS = 22;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        FIN  = 2'b10
    } state_e;

endpackage

// File: rtl/fixed_point_alu_seq_if.sv
// Request/response bundle between a calculator controller (master) and the
// sequential fixed-point ALU (slave).
interface fixed_point_alu_seq_if
    import fxp_calc_pkg::*;
#(
    parameter int unsigned WIDTH = FXP_WIDTH
);

    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             ovf;
    logic             div0;

    modport master (
        output start, op, a, b,
        input  busy, done, result, ovf, div0
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, ovf, div0
    );

endinterface

// File: rtl/fxp_iter_divider.sv
// Restoring unsigned divider, one quotient bit per cycle after i_start.
// o_done is high during the final step; o_quo is valid from the following edge and held.
module fxp_iter_divider
    import fxp_calc_pkg::*;
#(
    parameter int unsigned NUM_W = DIV_ITERS,
    parameter int unsigned DEN_W = FXP_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [NUM_W-1:0] i_num,
    input  logic [DEN_W-1:0] i_den,
    output logic             o_done,
    output logic [NUM_W-1:0] o_quo
);

    localparam int unsigned CNT_W = $clog2(NUM_W);

    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [DEN_W-1:0] r_rem;
    logic [DEN_W-1:0] r_den;
    logic [NUM_W-1:0] r_quo;

    logic [DEN_W:0]   w_shift;
    logic [DEN_W:0]   w_trial;
    logic             w_fits;

    // Remainder stays below the divisor, so one extra bit holds the shifted value
    // and the trial subtraction's MSB is a clean borrow flag.
    assign w_shift = {r_rem, r_quo[NUM_W-1]};
    assign w_trial = w_shift - {1'b0, r_den};
    assign w_fits  = ~w_trial[DEN_W];

    assign o_done = r_busy && (r_cnt == CNT_W'(NUM_W - 1));
    assign o_quo  = r_quo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_rem  <= '0;
            r_den  <= '0;
            r_quo  <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            r_rem  <= '0;
            r_den  <= i_den;
            r_quo  <= i_num;
        end else if (r_busy) begin
            r_rem <= w_fits ? w_trial[DEN_W-1:0] : w_shift[DEN_W-1:0];
            r_quo <= {r_quo[NUM_W-2:0], w_fits};
            r_cnt <= r_cnt + CNT_W'(1);
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fixed_point_alu_seq.sv
// Sequential Q9.6 add/sub/mul/div core with registered result, ovf and div0 flags.
// Define FXP_SATURATE_EN to clamp overflowing results; otherwise they wrap.
module fixed_point_alu_seq
    import fxp_calc_pkg::*;
#(
    parameter int unsigned WIDTH     = FXP_WIDTH,
    parameter int unsigned FRAC_BITS = FXP_FRAC_BITS
) (
    input logic                  clk,
    input logic                  rst_n,
    fixed_point_alu_seq_if.slave bus
);

    localparam int unsigned PROD_W = 2 * WIDTH;
    localparam int unsigned NUM_W  = WIDTH + FRAC_BITS;
    localparam int unsigned MAG_W  = PROD_W - FRAC_BITS;
    localparam int unsigned CNT_W  = $clog2(NUM_W);

    localparam logic [MAG_W-1:0] MAG_POS_LIM = {{(MAG_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic [MAG_W-1:0] MAG_NEG_LIM = {{(MAG_W-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [WIDTH-1:0] sat_val(input logic neg);
        return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction

    state_e            r_state;
    state_e            w_state_d;
    op_e               r_op;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_mplier;
    logic [PROD_W-1:0] r_mcand;
    logic [PROD_W-1:0] r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;
    logic              r_done;
    logic [WIDTH-1:0]  r_result;
    logic              r_ovf;
    logic              r_div0;

    logic              w_accept;
    logic              w_exec_last;
    logic              w_div_start;
    logic              w_div_done;
    logic [NUM_W-1:0]  w_div_quo;
    logic [WIDTH-1:0]  w_mag_a;
    logic [WIDTH-1:0]  w_mag_b;
    logic [WIDTH:0]    w_sum;
    logic [MAG_W-1:0]  w_mag;
    logic              w_neg;
    logic              w_ovf;
    logic              w_div0;
    logic [WIDTH-1:0]  w_wrap;
    logic [WIDTH-1:0]  w_res;

    // 0x8000 maps to 32768 as an unsigned magnitude, which is what the datapath wants.
    assign w_mag_a     = bus.a[WIDTH-1] ? -bus.a : bus.a;
    assign w_mag_b     = bus.b[WIDTH-1] ? -bus.b : bus.b;
    assign w_accept    = (r_state == IDLE) && bus.start;
    assign w_div_start = w_accept && (op_e'(bus.op) == OP_DIV);

    assign w_sum = (r_op == OP_SUB) ? ({r_a[WIDTH-1], r_a} - {r_b[WIDTH-1], r_b})
                                    : ({r_a[WIDTH-1], r_a} + {r_b[WIDTH-1], r_b});

    fxp_iter_divider #(
        .NUM_W (NUM_W),
        .DEN_W (WIDTH)
    ) u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_div_start),
        .i_num   ({w_mag_a, {FRAC_BITS{1'b0}}}),
        .i_den   (w_mag_b),
        .o_done  (w_div_done),
        .o_quo   (w_div_quo)
    );

    always_comb begin
        w_exec_last = 1'b0;
        unique case (r_op)
            OP_ADD, OP_SUB: w_exec_last = 1'b1;
            OP_MUL:         w_exec_last = (r_cnt == CNT_W'(WIDTH - 1));
            OP_DIV:         w_exec_last = w_div_done;
        endcase
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            IDLE:    if (bus.start) w_state_d = EXEC;
            EXEC:    if (w_exec_last) w_state_d = FIN;
            FIN:     w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Sign, range check and wrap/saturate, consumed in FIN.
    always_comb begin
        w_neg  = 1'b0;
        w_mag  = '0;
        w_ovf  = 1'b0;
        w_div0 = 1'b0;
        w_wrap = '0;
        if (r_op == OP_ADD || r_op == OP_SUB) begin
            w_neg  = r_acc[WIDTH];
            w_ovf  = r_acc[WIDTH] ^ r_acc[WIDTH-1];
            w_wrap = r_acc[WIDTH-1:0];
        end else begin
            w_mag  = (r_op == OP_MUL) ? r_acc[PROD_W-1:FRAC_BITS] : MAG_W'(w_div_quo);
            // Gate the sign on a non-zero magnitude so zero never comes out negative.
            w_neg  = (r_a[WIDTH-1] ^ r_b[WIDTH-1]) && (w_mag != '0);
            w_ovf  = w_neg ? (w_mag > MAG_NEG_LIM) : (w_mag > MAG_POS_LIM);
            w_wrap = w_neg ? -w_mag[WIDTH-1:0] : w_mag[WIDTH-1:0];
        end
`ifdef FXP_SATURATE_EN
        w_res = w_ovf ? sat_val(w_neg) : w_wrap;
`else
        w_res = w_wrap;
`endif
        if (r_op == OP_DIV && r_b == '0) begin
            w_div0 = 1'b1;
            w_ovf  = 1'b0;
            w_res  = sat_val(r_a[WIDTH-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= OP_ADD;
            r_a      <= '0;
            r_b      <= '0;
            r_mplier <= '0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_div0   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op     <= op_e'(bus.op);
                        r_a      <= bus.a;
                        r_b      <= bus.b;
                        r_mcand  <= {{(PROD_W-WIDTH){1'b0}}, w_mag_a};
                        r_mplier <= w_mag_b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                    end
                end
                EXEC: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_op == OP_ADD || r_op == OP_SUB) begin
                        r_acc <= {{(PROD_W-WIDTH-1){1'b0}}, w_sum};
                    end else if (r_op == OP_MUL) begin
                        if (r_mplier[0]) begin
                            r_acc <= r_acc + r_mcand;
                        end
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                    end
                end
                FIN: begin
                    r_result <= w_res;
                    r_ovf    <= w_ovf;
                    r_div0   <= w_div0;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_cnt    <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign bus.ovf    = r_ovf;
    assign bus.div0   = r_div0;

endmodule
